// File: rtl/axilite_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axilite_pkg : shared AXI4-Lite write-path types and helpers        |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package axilite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_W  = 3'd1,
    WAIT_AW = 3'd2,
    DECODE  = 3'd3,
    ISSUE   = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Operands are zero-extended one bit past any supported address width so neither compare can wrap.
  function automatic logic in_window(input logic [64:0] addr,
                                     input logic [64:0] base,
                                     input logic [64:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axilite_skid_latch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axilite_skid_latch : one-entry capture register for an AXI channel |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module axilite_skid_latch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b1;
      dout  <= '0;
    end else if (valid && ready) begin
      dout  <= din;
      ready <= 1'b0;
    end else if (clear) begin
      ready <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axilite_csr_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axilite_csr_write_ctrl : AXI4-Lite write joiner and CSR sequencer  |
// | Revision               : 1.0                                       |
// +--------------------------------------------------------------------+
module axilite_csr_write_ctrl
  import axilite_pkg::*;
#(
  parameter int                  ADDR_SIZE    = 32,
  parameter int                  DATA_WIDTH   = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = '0,
  parameter int unsigned         WINDOW_BYTES = 16,
  parameter int unsigned         TIMEOUT      = 15,
  parameter logic [1:0]          RESP_OKAY    = AXI_RESP_OKAY,
  parameter logic [1:0]          RESP_SLVERR  = AXI_RESP_SLVERR,
  parameter logic [1:0]          RESP_DECERR  = AXI_RESP_DECERR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_SIZE-1:0]    awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ADDR_SIZE-1:0]    dp_addr,
  output logic                    dp_addr_good,
  output logic                    dp_wvalid,
  output logic [DATA_WIDTH-1:0]   dp_wdata,
  output logic [DATA_WIDTH/8-1:0] dp_wstrobe,
  input  logic [1:0]              dp_resp,
  input  logic                    dp_resp_valid
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                     state, state_next;
  logic                       aw_hs, w_hs, release_chan, addr_ok, timed_out;
  logic [ADDR_SIZE-1:0]       aw_addr_q;
  logic [DATA_WIDTH+STRB_W-1:0] w_q;
  logic [CNT_W-1:0]           cnt, cnt_next;
  logic [CNT_W:0]             cnt_inc;

  logic                       bvalid_next, dp_addr_good_next, dp_wvalid_next;
  logic [1:0]                 bresp_next;
  logic [ADDR_SIZE-1:0]       dp_addr_next;
  logic [DATA_WIDTH-1:0]      dp_wdata_next;
  logic [STRB_W-1:0]          dp_wstrobe_next;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  axilite_skid_latch #(.WIDTH(ADDR_SIZE)) u_aw_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (awvalid),
    .clear (release_chan),
    .din   (awaddr),
    .ready (awready),
    .dout  (aw_addr_q)
  );

  axilite_skid_latch #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (wvalid),
    .clear (release_chan),
    .din   ({wstrb, wdata}),
    .ready (wready),
    .dout  (w_q)
  );

  assign addr_ok   = in_window(65'(aw_addr_q), 65'(BASE_ADDR), 65'(WINDOW_BYTES));
  assign cnt_inc   = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == (CNT_W + 1)'(TIMEOUT));

  always_comb begin
    state_next        = state;
    bvalid_next       = bvalid;
    bresp_next        = bresp;
    dp_addr_next      = dp_addr;
    dp_addr_good_next = dp_addr_good;
    dp_wvalid_next    = dp_wvalid;
    dp_wdata_next     = dp_wdata;
    dp_wstrobe_next   = dp_wstrobe;
    cnt_next          = cnt;
    release_chan      = 1'b0;
    case (state)
      IDLE: begin
        if (aw_hs && w_hs) state_next = DECODE;
        else if (aw_hs)    state_next = WAIT_W;
        else if (w_hs)     state_next = WAIT_AW;
      end
      WAIT_W:  if (w_hs)  state_next = DECODE;
      WAIT_AW: if (aw_hs) state_next = DECODE;
      DECODE: begin
        if (addr_ok) begin
          state_next        = ISSUE;
          dp_addr_next      = aw_addr_q - BASE_ADDR;
          dp_addr_good_next = 1'b1;
          dp_wvalid_next    = 1'b1;
          dp_wdata_next     = w_q[DATA_WIDTH-1:0];
          dp_wstrobe_next   = w_q[DATA_WIDTH +: STRB_W];
          cnt_next          = '0;
        end else begin
          state_next  = RESP;
          bvalid_next = 1'b1;
          bresp_next  = RESP_DECERR;
        end
      end
      ISSUE: begin
        // A completion pulse in the same cycle as the timeout takes priority.
        if (dp_resp_valid) begin
          state_next        = RESP;
          bvalid_next       = 1'b1;
          bresp_next        = dp_resp;
          dp_wvalid_next    = 1'b0;
          dp_addr_good_next = 1'b0;
        end else if (timed_out) begin
          state_next        = RESP;
          bvalid_next       = 1'b1;
          bresp_next        = RESP_SLVERR;
          dp_wvalid_next    = 1'b0;
          dp_addr_good_next = 1'b0;
          dp_addr_next      = '0;
          dp_wdata_next     = '0;
          dp_wstrobe_next   = '0;
        end else begin
          cnt_next = cnt_inc[CNT_W-1:0];
        end
      end
      RESP: begin
        if (bready) begin
          state_next   = IDLE;
          bvalid_next  = 1'b0;
          release_chan = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
      dp_addr      <= '0;
      dp_addr_good <= 1'b0;
      dp_wvalid    <= 1'b0;
      dp_wdata     <= '0;
      dp_wstrobe   <= '0;
      cnt          <= '0;
    end else begin
      state        <= state_next;
      bvalid       <= bvalid_next;
      bresp        <= bresp_next;
      dp_addr      <= dp_addr_next;
      dp_addr_good <= dp_addr_good_next;
      dp_wvalid    <= dp_wvalid_next;
      dp_wdata     <= dp_wdata_next;
      dp_wstrobe   <= dp_wstrobe_next;
      cnt          <= cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/axilite_csr_write_ctrl.md
Name: axilite_csr_write_ctrl

Overview:
AXI4-Lite write-channel controller that sits in front of the CSR write-data datapath.
- Accepts AW and W beats independently, in either order or together, and joins them into one write.
- Sequences that write into the datapath, then returns the BRESP to the master.
- Decodes the address window: out-of-window writes get DECERR, and a non-responding datapath gets SLVERR after a timeout.

Parameters:
ADDR_SIZE, 32, AXI address width
DATA_WIDTH, 32, AXI data width; strobe width = DATA_WIDTH/8
BASE_ADDR, 0, first byte address of the CSR window
WINDOW_BYTES, 16, window size in bytes (DATA_SIZE/8 of the datapath)
TIMEOUT, 15, max cycles to wait for datapath resp_valid; 0 disables the timeout
RESP_OKAY/RESP_SLVERR/RESP_DECERR, 0/2/3, response encodings

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
awaddr  in  ADDR_SIZE  AXI write address
awvalid  in  1  AXI address valid
awready  out  1  AXI address ready
wdata  in  DATA_WIDTH  AXI write data
wstrb  in  DATA_WIDTH/8  AXI byte strobes
wvalid  in  1  AXI data valid
wready  out  1  AXI data ready
bresp  out  2  AXI write response
bvalid  out  1  AXI response valid
bready  in  1  AXI response ready
dp_addr  out  ADDR_SIZE  window-relative address to the datapath
dp_addr_good  out  1  datapath address qualifier
dp_wvalid  out  1  datapath write request
dp_wdata  out  DATA_WIDTH  datapath data
dp_wstrobe  out  DATA_WIDTH/8  datapath strobes
dp_resp  in  2  datapath response
dp_resp_valid  in  1  datapath one-cycle completion pulse

Behaviour:
- Reset (rst_n low, async): state=IDLE; awready=1, wready=1; bvalid=0, bresp=0; dp_* all 0; timeout counter=0.
- All outputs are registered.
- Latches: AW handshake (awvalid&&awready) captures awaddr and drops awready; W handshake captures wdata/wstrb and drops wready.
- States:
  - IDLE: both readys high. AW+W in the same cycle -> DECODE. AW only -> WAIT_W. W only -> WAIT_AW.
  - WAIT_W: awready=0, wready=1; W handshake -> DECODE.
  - WAIT_AW: wready=0, awready=1; AW handshake -> DECODE.
  - DECODE (1 cycle): in_window = (addr >= BASE_ADDR) && (addr - BASE_ADDR < WINDOW_BYTES), computed at ADDR_SIZE+1 bits so there is no wrap.
    - In window -> ISSUE, driving dp_addr = addr - BASE_ADDR, dp_addr_good=1, dp_wvalid=1, dp_wdata, dp_wstrobe.
    - Out of window -> RESP with bresp=DECERR; the datapath is not touched.
  - ISSUE: hold dp_* stable and count cycles.
    - dp_resp_valid -> capture dp_resp into bresp, clear dp_wvalid and dp_addr_good the next cycle, go to RESP.
    - Counter reaches TIMEOUT (TIMEOUT!=0) without resp_valid -> bresp=SLVERR, clear dp_*, go to RESP.
    - If dp_resp_valid and the timeout occur in the same cycle, dp_resp_valid wins.
  - RESP: bvalid=1, bresp held stable; bready -> bvalid=0, awready=wready=1, go to IDLE.
- Latency: AW+W together in cycle 0 -> DECODE in cycle 1 -> dp_wvalid in cycle 2 -> datapath pulse in cycle 3 -> bvalid in cycle 4.
- No new AW/W beat is accepted until B completes: one outstanding write.
- A dp_resp_valid arriving outside ISSUE is ignored.
- bready held high before bvalid asserts does not shorten RESP; bvalid is always visible for at least 1 cycle.
- Reset mid-transaction aborts it: no B is issued and dp_wvalid drops immediately (asynchronously).
- Timeout counter: width $clog2(TIMEOUT+1); cleared on entry to ISSUE.

Decomposition:
- Package axilite_pkg holds:
  - resp localparams (OKAY/EXOKAY/SLVERR/DECERR);
  - the state enum typedef (IDLE, WAIT_W, WAIT_AW, DECODE, ISSUE, RESP);
  - a window-check function.
- One sub-module is natural: axilite_skid_latch, the per-channel capture register with valid/ready, instantiated once for AW and once for W.

Test Plan:
- awaddr=0x8, wdata=0xDEADBEEF, wstrb=0xF, AW and W together in cycle 0, bready=1 -> dp_addr=0x8 with dp_wvalid high from cycle 2; datapath pulses OKAY in cycle 3; bvalid=1 with bresp=0 in cycle 4.
- W beat 3 cycles before AW (awaddr=0x4) -> wready=0 while waiting; single dp write at 0x4 with the latched wdata; exactly one B.
- awaddr=BASE_ADDR+0x10 with WINDOW_BYTES=16 -> dp_wvalid never asserts; bresp=3 (DECERR).
- Datapath never pulses, TIMEOUT=15 -> dp_wvalid high for 15 cycles, then drops; bresp=2 (SLVERR).
- bready held low for 5 cycles in RESP -> bvalid and bresp stable; awready=wready=0 throughout; a new AW is accepted only after the B handshake.
- rst_n pulsed low while in ISSUE -> all outputs return to reset values immediately; no B is issued; the next write completes normally.
